pc_sequencer: RTL and testbench

Next-PC controller for the fetch stage. Owns the program-counter register, presents the fetch address to instruction memory under a valid/ready handshake, and selects the next PC from sequential increment (+1, modulo 2^N), branch target, jump target or trap vector. Sits between the decode/execute redirect logic and instruction memory; applies stall and halt/resume so the fetch address is never lost or skipped.

---
 rtl/pc_seq_if.sv | 50 +++++
 rtl/pc_sequencer.sv | 138 +++++++++++++
 tb/tb_pc_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// pc_seq_if: fetch-stage bundle between the next-PC sequencer, the
// redirect logic and instruction memory.
//   master : the sequencer (drives fetch_valid/pc/pc_plus1/halted/fetch_cnt/epc)
//   slave  : the surrounding pipeline (drives stall/redirects/halt/resume/
//            trap/fetch_ready)
// Macro PC_SEQ_TRAP_EN adds the trap request and the saved-PC (epc) output.
interface pc_seq_if #(
  parameter int N     = 9,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             br_taken;
  logic [N-1:0]     br_target;
  logic             jmp;
  logic [N-1:0]     jmp_target;
  logic             halt;
  logic             resume;
  logic             fetch_ready;
  logic             fetch_valid;
  logic [N-1:0]     pc;
  logic [N-1:0]     pc_plus1;
  logic             halted;
  logic [CNT_W-1:0] fetch_cnt;
`ifdef PC_SEQ_TRAP_EN
  logic             trap;
  logic [N-1:0]     epc;

  modport master (
    input  stall, br_taken, br_target, jmp, jmp_target, halt, resume,
           fetch_ready, trap,
    output fetch_valid, pc, pc_plus1, halted, fetch_cnt, epc
  );
  modport slave (
    output stall, br_taken, br_target, jmp, jmp_target, halt, resume,
           fetch_ready, trap,
    input  fetch_valid, pc, pc_plus1, halted, fetch_cnt, epc
  );
`else
  modport master (
    input  stall, br_taken, br_target, jmp, jmp_target, halt, resume,
           fetch_ready,
    output fetch_valid, pc, pc_plus1, halted, fetch_cnt
  );
  modport slave (
    output stall, br_taken, br_target, jmp, jmp_target, halt, resume,
           fetch_ready,
    input  fetch_valid, pc, pc_plus1, halted, fetch_cnt
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// Owns the PC register, presents it to instruction memory with a
// valid/ready handshake and picks the next PC from +1 (mod 2^N), branch,
// jump or trap vector. States BOOT -> RUN <-> HALT.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pc_seq_if.master (stall, br_taken/br_target, jmp/jmp_target,
//          halt, resume, fetch_ready, [trap] in; fetch_valid, pc, pc_plus1,
//          halted, fetch_cnt, [epc] out)
// Optional feature macro: PC_SEQ_TRAP_EN (trap input, epc output, trap has
// top priority in RUN and HALT and leaves HALT).
module pc_sequencer #(
  parameter int           N        = 9,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}},
  parameter logic [N-1:0] TRAP_VEC = 9'h1F0,
  parameter int           CNT_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  pc_seq_if.master    bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state_q;
  logic [N-1:0]     pc_q;
  logic             fetch_valid_q;
  logic             halted_q;
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [N-1:0]     pc_plus1_s;
  logic             accept_s;

  // Increment wraps naturally at 2^N by truncation.
  assign pc_plus1_s = pc_q + {{(N-1){1'b0}}, 1'b1};

  // fetch_valid_q mirrors (state_q == RUN); it is kept as its own flop so the
  // handshake output comes straight from a register.
  assign accept_s = fetch_valid_q & bus.fetch_ready & ~bus.stall;

`ifdef PC_SEQ_TRAP_EN
  logic [N-1:0] epc_q;
  assign bus.epc = epc_q;
`else
  logic unused_trap_vec_s;
  assign unused_trap_vec_s = ^TRAP_VEC;
`endif

  // Sequencer FSM, PC register, fetch counter and saved PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_cnt_q   <= {CNT_W{1'b0}};
`ifdef PC_SEQ_TRAP_EN
      epc_q         <= {N{1'b0}};
`endif
    end else begin
      // Counts every accepted fetch, including one that coincides with a
      // redirect (the address was consumed even though the PC moves away).
      if (accept_s) begin
        fetch_cnt_q <= fetch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          fetch_valid_q <= 1'b1;
          halted_q      <= 1'b0;
        end

        RUN: begin
          // Redirects ignore stall/fetch_ready: the pending fetch is dropped.
`ifdef PC_SEQ_TRAP_EN
          if (bus.trap) begin
            pc_q  <= TRAP_VEC;
            epc_q <= pc_q;
          end else
`endif
          if (bus.jmp) begin
            pc_q <= bus.jmp_target;
          end else if (bus.br_taken) begin
            pc_q <= bus.br_target;
          end else if (bus.halt) begin
            // Halt still lets the current fetch retire if it was accepted,
            // so resume continues at the following address.
            state_q       <= HALT;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b1;
            if (accept_s) begin
              pc_q <= pc_plus1_s;
            end
          end else if (accept_s) begin
            pc_q <= pc_plus1_s;
          end
        end

        HALT: begin
          // Branches and jumps are meaningless while halted; only trap or
          // resume leave this state.
`ifdef PC_SEQ_TRAP_EN
          if (bus.trap) begin
            pc_q          <= TRAP_VEC;
            epc_q         <= pc_q;
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
          end else
`endif
          if (bus.resume) begin
            state_q       <= RUN;
            fetch_valid_q <= 1'b1;
            halted_q      <= 1'b0;
          end
        end

        default: begin
          state_q       <= BOOT;
          fetch_valid_q <= 1'b0;
          halted_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_valid = fetch_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus1    = pc_plus1_s;
  assign bus.halted      = halted_q;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam int N     = 9;
  localparam int CNT_W = 16;
  localparam int PC_MOD  = 512;
  localparam int CNT_MOD = 65536;
  localparam int TRAPV   = 496;   // 9'h1F0

  logic clk = 1'b0;
  logic rst = 1'b1;

  pc_seq_if #(.N(N), .CNT_W(CNT_W)) bus ();

  pc_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic       stall;
    logic       br;
    logic [8:0] bt;
    logic       jmp;
    logic [8:0] jt;
    logic       halt;
    logic       resume;
    logic       ready;
    int         e_pc;
    logic       e_valid;
    logic       e_halted;
    int         e_cnt;
  } vec_t;

  vec_t vq[$];

  // Behavioural reference state for the random phase.
  int m_pc, m_cnt, m_epc;
  bit m_boot, m_halt;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    total++;
    if (act != exp)
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    else
      passed++;
  endtask

  task automatic add(input logic st, input logic br, input int bt, input logic jp,
                     input int jt, input logic hl, input logic rs, input logic rd,
                     input int ep, input logic ev, input logic eh, input int ec);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt[8:0]; v.jmp = jp; v.jt = jt[8:0];
    v.halt = hl; v.resume = rs; v.ready = rd;
    v.e_pc = ep; v.e_valid = ev; v.e_halted = eh; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic drive(input logic st, input logic br, input logic [8:0] bt,
                       input logic jp, input logic [8:0] jt, input logic hl,
                       input logic rs, input logic rd, input logic tr);
    bus.stall = st; bus.br_taken = br; bus.br_target = bt;
    bus.jmp = jp; bus.jmp_target = jt; bus.halt = hl; bus.resume = rs;
    bus.fetch_ready = rd;
`ifdef PC_SEQ_TRAP_EN
    bus.trap = tr;
`else
    if (tr) $display("note: trap requested without trap support");
`endif
  endtask

  task automatic chk_outputs(input string tag, input int idx, input int e_pc,
                             input logic e_valid, input logic e_halted, input int e_cnt);
    chk({tag, ".pc"},          idx, int'(bus.pc),          e_pc);
    chk({tag, ".pc_plus1"},    idx, int'(bus.pc_plus1),    (e_pc + 1) % PC_MOD);
    chk({tag, ".fetch_valid"}, idx, int'(bus.fetch_valid), int'(e_valid));
    chk({tag, ".halted"},      idx, int'(bus.halted),      int'(e_halted));
    chk({tag, ".fetch_cnt"},   idx, int'(bus.fetch_cnt),   e_cnt);
  endtask

  // Reference: one clock edge applied to the model, straight from the rules.
  task automatic model_step(input logic st, input logic br, input logic [8:0] bt,
                            input logic jp, input logic [8:0] jt, input logic hl,
                            input logic rs, input logic rd, input logic tr);
    bit running;
    bit acc;
    running = !m_boot && !m_halt;
    acc = running && rd && !st;
    if (acc) m_cnt = (m_cnt + 1) % CNT_MOD;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_halt) begin
      if (tr) begin
        m_epc = m_pc; m_pc = TRAPV; m_halt = 0;
      end else if (rs) begin
        m_halt = 0;
      end
    end else begin
      if (tr) begin
        m_epc = m_pc; m_pc = TRAPV;
      end else if (jp) m_pc = int'(jt);
      else if (br) m_pc = int'(bt);
      else if (hl) begin
        m_halt = 1;
        if (acc) m_pc = (m_pc + 1) % PC_MOD;
      end else if (acc) m_pc = (m_pc + 1) % PC_MOD;
    end
  endtask

  initial begin
    logic st, br, jp, hl, rs, rd, tr;
    logic [8:0] bt, jt;

    drive(1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 0, 0, 1'b0, 1'b0, 0);
`ifdef PC_SEQ_TRAP_EN
    chk("reset.epc", 0, int'(bus.epc), 0);
`endif
    rst = 1'b0;

    // ---- directed vectors: st br bt jmp jt halt resume ready | pc valid halted cnt
    add(0,0,  0,0,  0,0,0,1,   0,1,0,0);  // BOOT -> RUN
    add(0,0,  0,0,  0,0,0,1,   1,1,0,1);
    add(0,0,  0,0,  0,0,0,1,   2,1,0,2);
    add(0,0,  0,0,  0,0,0,1,   3,1,0,3);
    add(0,0,  0,0,  0,0,0,0,   3,1,0,3);  // not ready: hold, valid stays
    add(0,0,  0,0,  0,0,0,0,   3,1,0,3);
    add(1,0,  0,0,  0,0,0,1,   3,1,0,3);  // stalled
    add(1,1, 40,1, 80,0,0,1,  80,1,0,3);  // jmp beats br, despite stall
    add(0,1,200,0,  0,0,0,1, 200,1,0,4);  // redirect + accept: count still moves
    add(0,0,  0,0,  0,1,0,1, 201,0,1,5);  // halt accepted -> pc+1
    add(0,1,  5,1,  9,0,0,1, 201,0,1,5);  // redirects ignored in HALT
    add(0,0,  0,0,  0,0,1,0, 201,1,0,5);  // resume
    add(0,0,  0,1,511,0,0,0, 511,1,0,5);
    add(0,0,  0,0,  0,0,0,1,   0,1,0,6);  // wrap 1FF -> 0
    add(0,0,  0,0,  0,1,0,0,   0,0,1,6);  // halt unaccepted: hold
    add(0,0,  0,0,  0,0,1,1,   0,1,0,6);
    add(0,0,  0,1,  7,1,0,0,   7,1,0,6);  // redirect beats halt
    add(0,0,  0,0,  0,0,0,1,   8,1,0,7);

    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].br, vq[i].bt, vq[i].jmp, vq[i].jt,
            vq[i].halt, vq[i].resume, vq[i].ready, 1'b0);
      @(posedge clk);
      #1;
      chk_outputs("vec", i, vq[i].e_pc, vq[i].e_valid, vq[i].e_halted, vq[i].e_cnt);
    end

`ifdef PC_SEQ_TRAP_EN
    // ---- trap out of HALT at pc=8 ----
    drive(1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_outputs("trap_halt", 0, 8, 1'b0, 1'b1, 7);
    drive(1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk_outputs("trap_halt", 1, TRAPV, 1'b1, 1'b0, 7);
    chk("trap_halt.epc", 1, int'(bus.epc), 8);
`endif

    // ---- asynchronous reset mid-run, checked before any clock edge ----
    drive(1'b0, 1'b0, 9'd0, 1'b0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    chk_outputs("async_rst", 0, 0, 1'b0, 1'b0, 0);
`ifdef PC_SEQ_TRAP_EN
    chk("async_rst.epc", 0, int'(bus.epc), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // ---- randomized run against the reference model ----
    m_pc = 0; m_cnt = 0; m_epc = 0; m_boot = 1; m_halt = 0;
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom % 4) == 0;
      br = ($urandom % 6) == 0;
      jp = ($urandom % 8) == 0;
      hl = ($urandom % 16) == 0;
      rs = ($urandom % 3) == 0;
      rd = ($urandom % 4) != 0;
`ifdef PC_SEQ_TRAP_EN
      tr = ($urandom % 32) == 0;
`else
      tr = 1'b0;
`endif
      bt = 9'($urandom);
      jt = ($urandom % 8 == 0) ? 9'h1FF : 9'($urandom);
      drive(st, br, bt, jp, jt, hl, rs, rd, tr);
      model_step(st, br, bt, jp, jt, hl, rs, rd, tr);
      @(posedge clk);
      #1;
      chk_outputs("rand", c, m_pc, !m_boot && !m_halt, m_halt, m_cnt);
`ifdef PC_SEQ_TRAP_EN
      chk("rand.epc", c, int'(bus.epc), m_epc);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
